// File: rtl/sd_card_sd_dat_in.sv
// Avalon-MM parallel input port for the SD DAT[3:0] lines: synchronizer, any-edge capture, masked level IRQ.
// Define SD_CARD_SD_DAT_IN_FILTER_EN to insert a 4-clock per-bit glitch filter ahead of data_in.
module sd_card_sd_dat_in (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [3:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_data_prev;
    logic [3:0]  r_irq_mask;
    logic [3:0]  r_edge_capture;
    logic [31:0] r_readdata;

    logic [3:0]  w_data_in;
    logic [3:0]  w_edge;
    logic [3:0]  w_clr;
    logic        w_wr;
    logic [31:0] w_rd_mux;
    logic        w_unused_wd;

    // Upper write-data bits carry no register state.
    assign w_unused_wd = ^writedata[31:4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SD_CARD_SD_DAT_IN_FILTER_EN
    logic [3:0]       r_data_filt;
    logic [3:0][1:0]  r_stab_cnt;

    // A bit follows sync2 only after disagreeing for four straight clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_filt <= 4'd0;
            r_stab_cnt  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_data_filt[i]) begin
                    if (r_stab_cnt[i] == 2'd3) begin
                        r_data_filt[i] <= r_sync2[i];
                        r_stab_cnt[i]  <= 2'd0;
                    end else begin
                        r_stab_cnt[i]  <= r_stab_cnt[i] + 2'd1;
                    end
                end else begin
                    r_stab_cnt[i] <= 2'd0;
                end
            end
        end
    end

    assign w_data_in = r_data_filt;
`else
    assign w_data_in = r_sync2;
`endif

    assign w_edge = w_data_in ^ r_data_prev;
    assign w_wr   = chipselect && !write_n;
    assign w_clr  = (w_wr && address == 2'd3) ? writedata[3:0] : 4'd0;

    // A fresh edge overrides a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_prev    <= 4'd0;
            r_irq_mask     <= 4'd0;
            r_edge_capture <= 4'd0;
        end else begin
            r_data_prev    <= w_data_in;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            if (w_wr && address == 2'd2) begin
                r_irq_mask <= writedata[3:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (address)
            2'd0:    w_rd_mux = {28'd0, w_data_in};
            2'd2:    w_rd_mux = {28'd0, r_irq_mask};
            2'd3:    w_rd_mux = {28'd0, r_edge_capture};
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= chipselect ? w_rd_mux : 32'd0;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: doc/sd_card_sd_dat_in.md
SD_CARD_SD_DAT_IN -- requirements
Module: SD_CARD_sd_dat_in

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock for all registers.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 address  input  2  Avalon-MM slave register select.
REQ-005 chipselect  input  1  Avalon-MM slave select, active high.
REQ-006 write_n  input  1  Avalon-MM write strobe, active low.
REQ-007 writedata  input  32  Avalon-MM write data.
REQ-008 in_port  input  4  asynchronous SD DAT[3:0] line levels from the pads.
REQ-009 readdata  output  32  registered Avalon-MM read data.
REQ-010 irq  output  1  level interrupt, active high.

Function
REQ-011 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2); data_in = sync2 without filtering (see REQ-030).
REQ-012 Register map: address 0 = data_in (RO), 1 = reserved, reads 0, 2 = irq_mask[3:0] (RW), 3 = edge_capture[3:0] (read, write-1-to-clear).
REQ-013 A write SHALL occur when chipselect=1 and write_n=0 on a rising clk edge; writes to addresses 0 and 1 SHALL be ignored.
REQ-014 A write to address 2 SHALL load irq_mask from writedata[3:0]; writedata[31:4] SHALL be ignored.
REQ-015 data_prev SHALL register data_in every clock; edge[i] = data_in[i] XOR data_prev[i] (rising and falling edges both detected).
REQ-016 edge_capture[i] SHALL be set on the clock after edge[i]=1 and held until cleared.
REQ-017 A write to address 3 with writedata[i]=1 SHALL clear edge_capture[i]; bits with writedata[i]=0 SHALL be unchanged.
REQ-018 If edge[i]=1 and a clear of bit i occur on the same clock, set SHALL win and edge_capture[i] SHALL be 1.
REQ-019 readdata SHALL be registered every clock as the zero-extended value of the addressed register, qualified by chipselect (0 when chipselect=0), giving read latency 1.
REQ-020 Reads SHALL have no side effects.
REQ-021 irq SHALL equal OR over i of (edge_capture[i] AND irq_mask[i]), driven from registers only.
REQ-022 Latency without filter: in_port change reaches data_in after 2 clocks and edge_capture after 3 clocks.
REQ-023 A pulse on in_port shorter than one clock period MAY be missed and SHALL NOT cause metastable output.

Reset
REQ-024 Asserting reset_n low SHALL immediately clear sync1, sync2, data_prev, irq_mask, edge_capture and readdata to 0, and SHALL clear the filter state when the filter is present.
REQ-025 irq SHALL be 0 while reset_n is low.
REQ-026 After release, data_prev starts at 0, so an in_port line held high SHALL set its edge_capture bit once; software clears it after reset.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no partial register update.

Configuration
REQ-028 Macro SD_CARD_SD_DAT_IN_FILTER_EN SHALL select the glitch filter.
REQ-029 Without the macro, data_in = sync2 and the block SHALL contain no filter logic.
REQ-030 With the macro, each bit SHALL have a 2-bit stability counter; data_in[i] SHALL take sync2[i] only after sync2[i] differs from data_in[i] for 4 consecutive clocks; any return to equality SHALL reset the counter to 0.
REQ-031 With the macro, the REQ-022 latencies SHALL increase by 4 clocks; the register map and edge semantics SHALL be unchanged.

Verification
REQ-032 Reset, in_port=4'h0, read addr 0/2/3 -> readdata 0, 0, 0 one clock after each read; irq=0.
REQ-033 in_port 0->4'hA, wait 5 clocks, read addr 3 -> 4'hA; write addr 2 = 4'h2 -> irq=1; write addr 3 = 4'h2 -> irq=0, edge_capture=4'h8.
REQ-034 Toggle in_port[0] on the same clock edge_capture[0] is cleared -> edge_capture[0]=1 (set wins).
REQ-035 Write addr 0 = 32'hFFFFFFFF, then read addr 0 with in_port=4'h5 settled -> readdata 32'h5; read addr 1 -> 0.
REQ-036 With SD_CARD_SD_DAT_IN_FILTER_EN: 3-clock-wide pulse on in_port[1] -> data_in and edge_capture unchanged; 6-clock-wide pulse -> edge_capture[1]=1, readdata addr 0 bit1=1 at clock 6.
REQ-037 Assert reset_n for half a clock with irq=1 and mask=4'hF -> irq, irq_mask, edge_capture = 0 immediately.
